// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the IF/MEM single-port RAM arbiter.
//   ADDR_W_DEF / DATA_W_DEF : default RAM word-address and data widths
//   resp_e                  : owner of the response returned one cycle after a grant
//   resp_t                  : registered response descriptor (owner + load flag)
package mem_port_arbiter_pkg;
  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_IF   = 2'd1,
    RESP_MEM  = 2'd2,
    RESP_ERR  = 2'd3
  } resp_e;

  typedef struct packed {
    resp_e owner;
    logic  ld;     // MEM access was a load; stores return zero data
  } resp_t;
endpackage

// File: rtl/starve_counter.sv
// Counts consecutive cycles where IF requests but loses to MEM.
//   clk, rst : clock, async active-high reset
//   if_req   : IF is requesting this cycle
//   if_gnt   : IF granted this cycle
//   mem_gnt  : MEM granted this cycle
//   at_max   : counter has reached STARVE_MAX; IF must win this cycle
module starve_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic if_gnt,
  input  logic mem_gnt,
  output logic at_max
);
  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [CW-1:0] cnt, cnt_d;

  assign at_max = (cnt == CW'(STARVE_MAX));

  always_comb begin
    cnt_d = cnt;
    if (!if_req || if_gnt)       cnt_d = '0;
    else if (mem_gnt && !at_max) cnt_d = cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt_d;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch (IF) and load/store (MEM) onto one single-port RAM.
// MEM has priority unless IF has been starved STARVE_MAX cycles in a row.
// Every grant returns a response exactly one cycle later; fully pipelined.
//   clk, rst                              : clock, async active-high reset
//   if_req/if_addr -> if_gnt/if_valid/if_rdata/if_stall : fetch port
//   mem_req/mem_we/mem_addr/mem_wdata -> mem_gnt/mem_valid/mem_rdata/mem_err : data port
//   ram_en/ram_we/ram_addr/ram_wdata, ram_rdata : RAM side, read data one cycle after ram_en
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [31:0]       mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_gnt,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_err,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);
  logic  at_max, if_win, mem_win, mem_ok;
  resp_t resp_q, resp_d;

  // Byte-offset bits and bits above the RAM range are not decoded.
  logic unused_addr;
  assign unused_addr = ^{if_addr[31:ADDR_W+2], if_addr[1:0], mem_addr[31:ADDR_W+2]};

  starve_counter #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk    (clk),
    .rst    (rst),
    .if_req (if_req),
    .if_gnt (if_win),
    .mem_gnt(mem_win),
    .at_max (at_max)
  );

  always_comb begin
    if_win  = !rst && if_req && (!mem_req || at_max);
    mem_win = !rst && mem_req && !if_win;
    // misaligned MEM is still granted, but never reaches the RAM
    mem_ok  = mem_win && (mem_addr[1:0] == 2'b00);

    if_gnt    = if_win;
    mem_gnt   = mem_win;
    if_stall  = if_req && !if_win;
    ram_en    = if_win || mem_ok;
    ram_we    = mem_ok && mem_we;
    ram_addr  = '0;
    if (if_win)      ram_addr = if_addr[ADDR_W+1:2];
    else if (mem_ok) ram_addr = mem_addr[ADDR_W+1:2];
    ram_wdata = ram_we ? mem_wdata : '0;

    resp_d = '{owner: RESP_NONE, ld: 1'b0};
    if (if_win)       resp_d = '{owner: RESP_IF,  ld: 1'b0};
    else if (mem_ok)  resp_d = '{owner: RESP_MEM, ld: !mem_we};
    else if (mem_win) resp_d = '{owner: RESP_ERR, ld: 1'b0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) resp_q <= '{owner: RESP_NONE, ld: 1'b0};
    else     resp_q <= resp_d;
  end

  always_comb begin
    if_valid  = !rst && (resp_q.owner == RESP_IF);
    mem_valid = !rst && ((resp_q.owner == RESP_MEM) || (resp_q.owner == RESP_ERR));
    mem_err   = !rst && (resp_q.owner == RESP_ERR);
    if_rdata  = if_valid ? ram_rdata : '0;
    mem_rdata = (!rst && resp_q.owner == RESP_MEM && resp_q.ld) ? ram_rdata : '0;
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;
  localparam int SM     = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req, mem_req, mem_we;
  logic [31:0]       if_addr, mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              if_gnt, if_valid, if_stall, mem_gnt, mem_valid, mem_err;
  logic [DATA_W-1:0] if_rdata, mem_rdata;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid),
    .if_rdata(if_rdata), .if_stall(if_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_valid(mem_valid), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // Bench-side single-port RAM with a backdoor preload port.
  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
  logic              bd_we = 1'b0;
  logic [ADDR_W-1:0] bd_addr = '0;
  logic [DATA_W-1:0] bd_data = '0;
  always @(posedge clk) begin
    if (bd_we) ram[bd_addr] <= bd_data;
    else if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      else        ram_rdata <= ram[ram_addr];
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // One cycle: drive inputs just after the edge, return mid-cycle for sampling.
  task automatic cyc(input logic ir, input logic [31:0] ia, input logic mr, input logic mw,
                     input logic [31:0] ma, input logic [31:0] md);
    @(posedge clk); #1;
    if_req = ir; if_addr = ia; mem_req = mr; mem_we = mw; mem_addr = ma; mem_wdata = md;
    #4;
  endtask

  task automatic poke(input int a, input logic [31:0] d);
    @(posedge clk); #1;
    bd_we = 1'b1; bd_addr = ADDR_W'(a); bd_data = d;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; if_req = 0; mem_req = 0; mem_we = 0; if_addr = 0; mem_addr = 0; mem_wdata = 0;
    #2;
    if_req = 1; if_addr = 32'h44; mem_req = 1; mem_we = 1; mem_addr = 32'h48; mem_wdata = 32'h1234_5678;
    #1;
    n_tests++;
    if ({if_gnt, mem_gnt, ram_en, ram_we} !== 4'b0) begin
      n_fail++; $display("FAIL reset_grants got=%b exp=0000", {if_gnt, mem_gnt, ram_en, ram_we});
    end
    n_tests++;
    if ({if_valid, mem_valid, mem_err, if_rdata, mem_rdata} !== '0) begin
      n_fail++; $display("FAIL reset_resp got=%b%b%b %h %h exp=0", if_valid, mem_valid, mem_err, if_rdata, mem_rdata);
    end
    n_tests++;
    if ({ram_addr, ram_wdata} !== '0) begin
      n_fail++; $display("FAIL reset_ram got=%h %h exp=0", ram_addr, ram_wdata);
    end
    @(posedge clk); #1;
    rst = 1'b0; if_req = 0; mem_req = 0;
    #4;
    n_tests++;
    if ({ram_en, ram_we, ram_addr, ram_wdata, if_stall} !== '0) begin
      n_fail++; $display("FAIL idle_ram got=%b%b %h %h %b exp=0", ram_en, ram_we, ram_addr, ram_wdata, if_stall);
    end
  endtask

  task automatic test_if_only;
    poke(4, 32'h0050_0093);
    cyc(1, 32'h10, 0, 0, 0, 0);
    n_tests++;
    if ({if_gnt, mem_gnt, ram_en, ram_we, if_stall} !== 5'b10100 || ram_addr !== 14'd4) begin
      n_fail++; $display("FAIL if_grant got=%b addr=%0d exp=10100 addr=4", {if_gnt, mem_gnt, ram_en, ram_we, if_stall}, ram_addr);
    end
    cyc(0, 0, 0, 0, 0, 0);
    n_tests++;
    if (if_valid !== 1'b1 || if_rdata !== 32'h0050_0093 || mem_valid !== 1'b0) begin
      n_fail++; $display("FAIL if_resp got=%b %h %b exp=1 00500093 0", if_valid, if_rdata, mem_valid);
    end
    cyc(0, 0, 0, 0, 0, 0);
    n_tests++;
    if (if_valid !== 1'b0 || if_rdata !== '0) begin
      n_fail++; $display("FAIL if_resp_idle got=%b %h exp=0 0", if_valid, if_rdata);
    end
  endtask

  task automatic test_collision;
    cyc(1, 32'h40, 1, 1, 32'h20, 32'hDEAD_BEEF);
    n_tests++;
    if ({if_gnt, mem_gnt, ram_en, ram_we, if_stall} !== 5'b01111 || ram_addr !== 14'd8 ||
        ram_wdata !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL coll_grant got=%b addr=%0d wd=%h exp=01111 addr=8 wd=deadbeef",
                         {if_gnt, mem_gnt, ram_en, ram_we, if_stall}, ram_addr, ram_wdata);
    end
    cyc(0, 0, 1, 0, 32'h20, 0);
    n_tests++;
    if (mem_valid !== 1'b1 || mem_rdata !== '0 || mem_err !== 1'b0 || if_valid !== 1'b0) begin
      n_fail++; $display("FAIL coll_store_resp got=%b %h %b %b exp=1 0 0 0", mem_valid, mem_rdata, mem_err, if_valid);
    end
    cyc(0, 0, 0, 0, 0, 0);
    n_tests++;
    if (mem_valid !== 1'b1 || mem_rdata !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL coll_readback got=%b %h exp=1 deadbeef", mem_valid, mem_rdata);
    end
  endtask

  task automatic test_starvation;
    logic [1:0] exp_g [6] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01};
    cyc(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      cyc(1, 32'h10, 1, 0, 32'h20 + 32'(4 * i), 0);
      n_tests++;
      if ({if_gnt, mem_gnt} !== exp_g[i]) begin
        n_fail++; $display("FAIL starve_c%0d got=%b exp=%b", i, {if_gnt, mem_gnt}, exp_g[i]);
      end
    end
    cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_misaligned;
    cyc(0, 0, 1, 0, 32'h22, 0);
    n_tests++;
    if ({mem_gnt, ram_en, ram_we} !== 3'b100) begin
      n_fail++; $display("FAIL misal_grant got=%b exp=100", {mem_gnt, ram_en, ram_we});
    end
    cyc(0, 0, 0, 0, 0, 0);
    n_tests++;
    if ({mem_valid, mem_err} !== 2'b11 || mem_rdata !== '0) begin
      n_fail++; $display("FAIL misal_resp got=%b %h exp=11 0", {mem_valid, mem_err}, mem_rdata);
    end
  endtask

  task automatic test_back_to_back;
    poke(5, 32'hA1A1_0001); poke(6, 32'hB2B2_0002); poke(7, 32'hC3C3_0003);
    cyc(1, 32'h14, 0, 0, 0, 0);
    n_tests++;
    if ({if_gnt, mem_gnt} !== 2'b10) begin
      n_fail++; $display("FAIL b2b_g0 got=%b exp=10", {if_gnt, mem_gnt});
    end
    cyc(0, 0, 1, 0, 32'h18, 0);
    n_tests++;
    if ({if_valid, mem_valid, mem_gnt} !== 3'b101 || if_rdata !== 32'hA1A1_0001) begin
      n_fail++; $display("FAIL b2b_r0 got=%b %h exp=101 a1a10001", {if_valid, mem_valid, mem_gnt}, if_rdata);
    end
    cyc(1, 32'h1C, 0, 0, 0, 0);
    n_tests++;
    if ({if_valid, mem_valid, if_gnt} !== 3'b011 || mem_rdata !== 32'hB2B2_0002) begin
      n_fail++; $display("FAIL b2b_r1 got=%b %h exp=011 b2b20002", {if_valid, mem_valid, if_gnt}, mem_rdata);
    end
    cyc(0, 0, 0, 0, 0, 0);
    n_tests++;
    if ({if_valid, mem_valid} !== 2'b10 || if_rdata !== 32'hC3C3_0003) begin
      n_fail++; $display("FAIL b2b_r2 got=%b %h exp=10 c3c30003", {if_valid, mem_valid}, if_rdata);
    end
  endtask

  task automatic test_reset_mid;
    logic [1:0] exp_g [4] = '{2'b01, 2'b01, 2'b01, 2'b10};
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 32'h10, 1, 0, 32'h20, 0);
    cyc(1, 32'h10, 1, 0, 32'h24, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    #4;
    n_tests++;
    if ({if_valid, mem_valid, mem_err, if_gnt, mem_gnt, ram_en} !== 6'b0) begin
      n_fail++; $display("FAIL rstmid_during got=%b exp=000000", {if_valid, mem_valid, mem_err, if_gnt, mem_gnt, ram_en});
    end
    @(posedge clk); #1;
    rst = 1'b0; if_req = 0; mem_req = 0;
    #4;
    n_tests++;
    if ({if_valid, mem_valid, mem_err} !== 3'b0) begin
      n_fail++; $display("FAIL rstmid_after got=%b exp=000", {if_valid, mem_valid, mem_err});
    end
    // A cleared counter lets MEM win exactly SM times before IF is forced.
    for (int i = 0; i < 4; i++) begin
      cyc(1, 32'h10, 1, 0, 32'h20, 0);
      n_tests++;
      if ({if_gnt, mem_gnt} !== exp_g[i]) begin
        n_fail++; $display("FAIL rstmid_starve_c%0d got=%b exp=%b", i, {if_gnt, mem_gnt}, exp_g[i]);
      end
    end
    cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_random;
    logic [31:0] mdl [64];
    int          starve, pk;
    logic [31:0] pd;
    logic        ir, mr, mw, eg_if, eg_mem, al;
    logic [31:0] ia, ma, md;
    logic [4:0]  exp_ctl;
    logic [ADDR_W-1:0] exp_addr;
    logic [31:0] exp_wd;
    for (int i = 0; i < 64; i++) begin
      mdl[i] = $urandom;
      poke(i, mdl[i]);
    end
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    starve = 0; pk = 0; pd = 0;
    for (int c = 0; c < 300; c++) begin
      ir = ($urandom_range(0, 3) != 0);
      mr = ($urandom_range(0, 4) < 3);
      mw = $urandom_range(0, 1) != 0;
      ia = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
      ma = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      if ($urandom_range(0, 4) == 0) ma[1:0] = 2'($urandom_range(1, 3));
      md = $urandom;
      cyc(ir, ia, mr, mw, ma, md);
      // response of the previous cycle's grant
      n_tests++;
      if (if_valid !== (pk == 1) || if_rdata !== ((pk == 1) ? pd : 32'h0) ||
          mem_valid !== (pk >= 2) || mem_err !== (pk == 3) || mem_rdata !== ((pk == 2) ? pd : 32'h0)) begin
        n_fail++; $display("FAIL rnd_resp c%0d got=%b%b%b %h %h exp_kind=%0d data=%h",
                           c, if_valid, mem_valid, mem_err, if_rdata, mem_rdata, pk, pd);
      end
      eg_if  = ir && (!mr || starve == SM);
      eg_mem = mr && !eg_if;
      al     = (ma[1:0] == 2'b00);
      exp_ctl  = {eg_if, eg_mem, eg_if || (eg_mem && al), eg_mem && al && mw, ir && !eg_if};
      exp_addr = eg_if ? ADDR_W'(ia >> 2) : (eg_mem && al) ? ADDR_W'(ma >> 2) : '0;
      exp_wd   = (eg_mem && al && mw) ? md : 32'h0;
      n_tests++;
      if ({if_gnt, mem_gnt, ram_en, ram_we, if_stall} !== exp_ctl || ram_addr !== exp_addr || ram_wdata !== exp_wd) begin
        n_fail++; $display("FAIL rnd_grant c%0d got=%b %h %h exp=%b %h %h",
                           c, {if_gnt, mem_gnt, ram_en, ram_we, if_stall}, ram_addr, ram_wdata, exp_ctl, exp_addr, exp_wd);
      end
      if (eg_if) begin
        pk = 1; pd = mdl[ia[7:2]];
      end else if (eg_mem && !al) begin
        pk = 3; pd = 0;
      end else if (eg_mem && mw) begin
        pk = 2; pd = 0; mdl[ma[7:2]] = md;
      end else if (eg_mem) begin
        pk = 2; pd = mdl[ma[7:2]];
      end else begin
        pk = 0; pd = 0;
      end
      if (!ir || eg_if) starve = 0;
      else if (eg_mem && starve < SM) starve++;
    end
    cyc(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset;
    test_if_only;
    test_collision;
    test_starvation;
    test_misaligned;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, word-address width of the shared RAM.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter STARVE_MAX, default 3, max consecutive IF denials caused by MEM wins before IF is forced a grant.
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have ports if_req in 1, if_addr in 32: fetch request and byte address.
REQ-007 SHALL have ports if_gnt out 1, if_valid out 1, if_rdata out DATA_W: fetch grant, response strobe, instruction.
REQ-008 SHALL have ports mem_req in 1, mem_we in 1, mem_addr in 32, mem_wdata in DATA_W: load/store request.
REQ-009 SHALL have ports mem_gnt out 1, mem_valid out 1, mem_rdata out DATA_W, mem_err out 1: grant, response strobe, load data, misalignment flag.
REQ-010 SHALL have ports ram_en out 1, ram_we out 1, ram_addr out ADDR_W, ram_wdata out DATA_W, ram_rdata in DATA_W: single-port RAM, read data valid one cycle after ram_en.
REQ-011 SHALL have port if_stall, output, 1, holds fetch/IF buffer when IF requests but is not granted.

Function
REQ-012 SHALL grant at most one requester per cycle; if_gnt, mem_gnt, ram_en, ram_we, ram_addr, ram_wdata combinational from current requests and state.
REQ-013 SHALL give MEM priority over IF unless starve_cnt == STARVE_MAX, in which case IF wins that cycle.
REQ-014 SHALL increment starve_cnt (saturating at STARVE_MAX) each cycle IF requests and MEM is granted; clear it on any IF grant or any cycle if_req is low.
REQ-015 SHALL drive ram_addr = granted address[ADDR_W+1:2]; address bits [1:0] ignored for IF.
REQ-016 SHALL, for a MEM request with mem_addr[1:0] != 0, assert mem_gnt, suppress ram_en/ram_we, and respond next cycle with mem_valid=1, mem_err=1, mem_rdata=0.
REQ-017 SHALL register response owner resp_q in {RESP_NONE, RESP_IF, RESP_MEM, RESP_ERR} each cycle from the grant decision; latency request-grant to valid = 1 cycle.
REQ-018 SHALL in cycle after grant: RESP_IF -> if_valid=1, if_rdata=ram_rdata; RESP_MEM -> mem_valid=1, mem_rdata=ram_rdata for loads, 0 for stores; RESP_NONE -> both valid low.
REQ-019 SHALL hold if_rdata/mem_rdata at 0 whenever the corresponding valid is low.
REQ-020 SHALL accept back-to-back grants every cycle (fully pipelined, no bubble between accesses).
REQ-021 SHALL assert if_stall = if_req && !if_gnt.
REQ-022 SHALL, when no request is present, drive ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0.
REQ-023 SHALL treat a request deasserted before grant as withdrawn (no response).

Reset
REQ-024 SHALL on rst asynchronously clear resp_q to RESP_NONE and starve_cnt to 0.
REQ-025 SHALL drive if_valid=0, mem_valid=0, mem_err=0, rdata outputs 0 and all grants/ram controls 0 while rst is high.
REQ-026 SHALL discard any in-flight response when rst asserts mid-access; no valid after release.

Structure
REQ-027 SHALL place resp_q encoding (RESP_* 2-bit constants) and default ADDR_W/DATA_W in the shared CPU package.
REQ-028 SHALL be a single module; starvation counter may be a sub-module starve_counter, no other hierarchy.

Verification
REQ-029 SHALL test IF only: if_req=1, if_addr=0x10, ram returns 0x00500093 -> if_gnt cycle N, if_valid=1, if_rdata=0x00500093 cycle N+1, if_stall=0.
REQ-030 SHALL test collision: both req, mem_we=1, mem_addr=0x20, mem_wdata=0xDEADBEEF -> mem_gnt=1, ram_we=1, ram_addr=8, if_stall=1; mem_valid next cycle with mem_rdata=0.
REQ-031 SHALL test starvation: if_req and mem_req held 6 cycles, STARVE_MAX=3 -> grants MEM,MEM,MEM,IF,MEM,MEM.
REQ-032 SHALL test misaligned load mem_addr=0x22 -> ram_en=0, next cycle mem_valid=1, mem_err=1, mem_rdata=0.
REQ-033 SHALL test back-to-back: IF, MEM load, IF in consecutive cycles -> valids in the three following cycles routed to correct requester.
REQ-034 SHALL test reset mid-access: rst pulse in cycle after grant -> no if_valid/mem_valid, starve_cnt=0 after release.
